uart_packet_tx: RTL and testbench

Transmit-side counterpart of the team's packet UART receiver. On a start request it latches a 128-bit payload and serialises one fixed packet over 8N1 UART:
- 16-bit header
- 16 payload bytes
- 16-bit checksum

The packet is 20 bytes, driven on a single tx line. It sits between the core logic and the board TX pin.

---
 rtl/uart_packet_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_packet_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// Packet UART transmitter: header, 16 payload bytes and a 16-bit checksum sent as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 of every byte.
module uart_packet_tx #(
  parameter int unsigned clk_freq  = 100_000_000,
  parameter int unsigned baud_rate = 115_200,
  parameter logic [15:0] header    = 16'hA55A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic [2:0]   o_dbg_state
);

  localparam int unsigned CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_BYTE = 5'd19;

  // NEXT_BYTE has no encoding: its decision is taken on the last cycle of STOP_BIT.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_baud_cnt;
  logic [CW-1:0]   w_baud_next;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_next;
  logic [4:0]      r_byte_idx;
  logic [4:0]      w_byte_next;
  logic [127:0]    r_data;
  logic [15:0]     r_csum;
  logic [15:0]     w_csum_in;
  logic            r_done;
  logic            w_done_next;
  logic            w_load;
  logic            w_bit_end;
  logic [3:0]      w_pay_sel;
  logic [7:0]      w_byte;

  // Handshake: start is a request accepted only while busy is low (state IDLE);
  // acceptance latches data_in, and requests while busy are dropped, not queued.
  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  always_comb begin
    w_csum_in = '0;
    for (int i = 0; i < 16; i++) begin
      w_csum_in = w_csum_in + {8'd0, data_in[8*i +: 8]};
    end
  end

  // Payload byte 2 is data[127:120], byte 17 is data[7:0].
  always_comb begin
    w_pay_sel = 4'(5'd17 - r_byte_idx);
    case (r_byte_idx)
      5'd0:    w_byte = header[15:8];
      5'd1:    w_byte = header[7:0];
      5'd18:   w_byte = r_csum[15:8];
      5'd19:   w_byte = r_csum[7:0];
      default: w_byte = r_data[{w_pay_sel, 3'b000} +: 8];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_next   = r_bit_idx;
    w_byte_next  = r_byte_idx;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_bit_next  = 3'd0;
        w_byte_next = 5'd0;
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_bit_next   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_next = S_IDLE;
            w_byte_next  = 5'd0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_START;
            w_byte_next  = r_byte_idx + 5'd1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 5'd0;
      r_data     <= '0;
      r_csum     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_baud_cnt <= w_baud_next;
      r_bit_idx  <= w_bit_next;
      r_byte_idx <= w_byte_next;
      r_done     <= w_done_next;
      if (w_load) begin
        r_data <= data_in;
        r_csum <= w_csum_in;
      end
    end
  end

  always_comb begin
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = w_byte[r_bit_idx];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = ^w_byte;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: random payloads checked cycle-by-cycle against a frame-level line model.
module tb_uart_packet_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int PKT = 20 * FRAME * CPB;
  localparam logic [15:0] HDR = 16'hA55A;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] data_in;
  logic         tx;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_packet_tx #(
    .clk_freq (1_000_000),
    .baud_rate(100_000),
    .header   (HDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the 20 bytes a packet should carry.
  function automatic void build_model(input logic [127:0] p);
    int sum;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(HDR[15:8]);
    exp_q.push_back(HDR[7:0]);
    sum = 0;
    for (int i = 15; i >= 0; i--) begin
      b = p[8*i +: 8];
      exp_q.push_back(b);
      sum += int'(b);
    end
    sum = sum % 65536;
    exp_q.push_back(8'(sum / 256));
    exp_q.push_back(8'(sum % 256));
  endfunction

  // Expected line level k cycles after the start bit began.
  function automatic logic exp_line(input int k);
    int bi, by, pos;
    logic [7:0] b;
    bi  = k / CPB;
    by  = bi / FRAME;
    pos = bi % FRAME;
    b   = exp_q[by];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == FRAME - 1) return 1'b1;
    return ^b;
  endfunction

  // mode 0 plain, 1 extra start pulses mid-packet, 2 reset during byte 7, 3 data_in changes after acceptance
  task automatic run_pkt(input logic [127:0] p, input string tag, input int mode);
    int line_err, busy_err, done_err, bi, pos, by;
    logic [7:0] dec;
    logic par;
    build_model(p);
    line_err = 0; busy_err = 0; done_err = 0; dec = '0; par = 1'b0;
    start = 1'b1;
    data_in = p;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= PKT; k++) begin
      if (k == 0) check({tag, " start bit latency"}, tx, 1'b0);
      if (k < PKT) begin
        if (tx !== exp_line(k)) line_err++;
        if (busy !== 1'b1) busy_err++;
        if (done !== 1'b0) done_err++;
        bi  = k / CPB;
        pos = bi % FRAME;
        by  = bi / FRAME;
        if (k % CPB == CPB / 2) begin
          if (pos >= 1 && pos <= 8) dec[pos-1] = tx;
          if (pos == 9 && FRAME == 11) par = tx;
        end
        if (k % CPB == CPB - 1 && pos == FRAME - 1) begin
          check({tag, " byte"}, dec, exp_q[by]);
`ifdef UART_TX_PARITY_EN
          check({tag, " parity"}, par, ^exp_q[by]);
`endif
        end
      end else begin
        check({tag, " done at end"}, done, 1'b1);
        check({tag, " busy at end"}, busy, 1'b0);
        check({tag, " tx at end"}, tx, 1'b1);
      end
      if (mode == 1) begin
        if (k == 100 || k == 1500) start = 1'b1;
        if (k == 101 || k == 1501) start = 1'b0;
      end
      if (mode == 3 && k == 3) data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (mode == 2 && k == 7 * FRAME * CPB + 3 * CPB + 4) begin
        rst_n = 1'b0;
        #1;
        check({tag, " async rst tx"}, tx, 1'b1);
        check({tag, " async rst busy"}, busy, 1'b0);
        check({tag, " async rst done"}, done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k < PKT) @(negedge clk);
    end
    check({tag, " line errors"}, line_err, 0);
    check({tag, " busy errors"}, busy_err, 0);
    check({tag, " early done"}, done_err, 0);
  endtask

  task automatic idle_check(input int n, input string tag);
    int errs;
    errs = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    check(tag, errs, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle tx", tx, 1'b1);

    run_pkt(128'h0, "zero", 0);
    idle_check(2 * CPB, "zero idle");

    run_pkt(128'h000102030405060708090A0B0C0D0E0F, "ramp", 0);
    run_pkt({128{1'b1}}, "ones back2back", 0);
    idle_check(2 * CPB, "ones idle");

    run_pkt(rnd128(), "ignore start", 1);
    idle_check(3 * FRAME * CPB, "no second packet");

    run_pkt(rnd128(), "data change", 3);
    idle_check(CPB, "data change idle");

    run_pkt(rnd128(), "abort", 2);
    idle_check(5, "after abort idle");
    run_pkt(rnd128(), "fresh after abort", 0);
    idle_check(CPB, "fresh idle");

    run_pkt(128'h01, "last byte 01", 0);
    idle_check(CPB, "01 idle");

    for (int r = 0; r < 3; r++) begin
      run_pkt(rnd128(), "random", 0);
      idle_check($urandom_range(1, 3 * CPB), "random idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
